// File: rtl/uart_byte_sorter.sv
// uart_byte_sorter: collects N_BYTES received bytes, bubble-sorts them ascending
// (one compare per clock), then streams them to the UART transmitter one at a time.
module uart_byte_sorter #(
    parameter int unsigned N_BYTES = 8
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Done,
    output logic       o_busy,
    output logic       o_drop,
    output logic       o_frame_done
);

    localparam int unsigned AW = $clog2(N_BYTES);
    localparam int unsigned IW = AW + 1;
    localparam logic [IW-1:0] LastIdx  = IW'(N_BYTES - 1);
    localparam logic [IW-1:0] LastPass = IW'(N_BYTES - 2);
    localparam logic [AW-1:0] Addr0    = '0;

    typedef enum logic [1:0] {StCollect, StSort, StSend, StWaitTx} state_e;

    state_e        state_q;
    logic [7:0]    mem_q [N_BYTES];
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic          swapped_q;
    logic          tx_dv_q;
    logic [7:0]    tx_byte_q;
    logic          busy_q;
    logic          drop_q;
    logic          frame_done_q;

    logic [IW-1:0] j_nxt;
    logic [IW-1:0] rd_nxt;
    logic [IW-1:0] j_lim;
    logic [7:0]    cmp_lo;
    logic [7:0]    cmp_hi;
    logic          do_swap;

    // Compare-pair selection and pass limit for the current sort step
    always_comb begin
        j_nxt   = j_q + IW'(1);
        rd_nxt  = rd_idx_q + IW'(1);
        j_lim   = LastPass - i_q;
        cmp_lo  = mem_q[j_q[AW-1:0]];
        cmp_hi  = mem_q[j_nxt[AW-1:0]];
        do_swap = cmp_lo > cmp_hi;
    end

    // Main FSM: storage, sort counters and all registered outputs
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StCollect;
            for (int unsigned k = 0; k < N_BYTES; k++) begin
                mem_q[k] <= 8'h00;
            end
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            i_q          <= '0;
            j_q          <= '0;
            swapped_q    <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_dv_q      <= 1'b0;
            drop_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (i_Rx_DV && (state_q != StCollect)) begin
                drop_q <= 1'b1;
            end
            case (state_q)
                StCollect: begin
                    if (i_Rx_DV) begin
                        mem_q[wr_idx_q[AW-1:0]] <= i_Rx_Byte;
                        if (wr_idx_q == LastIdx) begin
                            wr_idx_q  <= '0;
                            i_q       <= '0;
                            j_q       <= '0;
                            swapped_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= StSort;
                        end else begin
                            wr_idx_q <= wr_idx_q + IW'(1);
                        end
                    end
                end
                StSort: begin
                    if (do_swap) begin
                        mem_q[j_q[AW-1:0]]   <= cmp_hi;
                        mem_q[j_nxt[AW-1:0]] <= cmp_lo;
                    end
                    swapped_q <= swapped_q | do_swap;
                    if (j_q < j_lim) begin
                        j_q <= j_nxt;
                    end else if (!(swapped_q || do_swap) || (i_q == LastPass)) begin
                        // Byte is loaded on entry so it is valid during SEND; a swap at
                        // j=0 in this same cycle moves the smaller byte into slot 0.
                        rd_idx_q  <= '0;
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= ((j_q == '0) && do_swap) ? cmp_hi : mem_q[Addr0];
                        state_q   <= StSend;
                    end else begin
                        i_q       <= i_q + IW'(1);
                        j_q       <= '0;
                        swapped_q <= 1'b0;
                    end
                end
                StSend: begin
                    state_q <= StWaitTx;
                end
                StWaitTx: begin
                    if (i_Tx_Done) begin
                        if (rd_idx_q == LastIdx) begin
                            rd_idx_q     <= '0;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= StCollect;
                        end else begin
                            rd_idx_q  <= rd_nxt;
                            tx_dv_q   <= 1'b1;
                            tx_byte_q <= mem_q[rd_nxt[AW-1:0]];
                            state_q   <= StSend;
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;
    assign o_busy       = busy_q;
    assign o_drop       = drop_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_byte_sorter.sv
// Scoreboard bench for uart_byte_sorter: driver pushes expected sorted bytes and
// timing, a monitor pops and compares whenever the DUT presents an output.
module tb_uart_byte_sorter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_done = 1'b0;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       o_busy;
    logic       o_drop;
    logic       o_frame_done;

    uart_byte_sorter #(.N_BYTES(N)) dut (
        .i_clock     (clk),
        .i_rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Done   (tx_done),
        .o_busy      (o_busy),
        .o_drop      (o_drop),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         first_dv_q[$];
    int         drop_q[$];
    int         mon_idx = 0;
    bit         expect_final = 1'b0;
    int         last_done_cyc = -10;
    int         fd_exp_cyc = -1;
    int         frames_done = 0;
    int         done_in_frame = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: number of compares of an early-exit bubble sort over the frame
    function automatic int bubble_cycles(input logic [7:0] f[$]);
        logic [7:0] a[$];
        logic [7:0] t;
        int cnt = 0;
        a = f;
        for (int i = 0; i < N - 1; i++) begin
            bit sw = 1'b0;
            for (int j = 0; j < N - 1 - i; j++) begin
                cnt++;
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        return cnt;
    endfunction

    // Driver is at posedge+1 on entry and exit
    task automatic send_frame(input logic [7:0] f[$], input bit sort_drop, input bit gaps);
        logic [7:0] s[$];
        int last = 0;
        check("busy_idle_before_frame", o_busy, 0);
        s = f;
        s.sort();
        foreach (s[k]) exp_q.push_back(s[k]);
        for (int k = 0; k < N; k++) begin
            rx_dv = 1'b1;
            rx_byte = f[k];
            if (k == N - 1) last = cyc;
            @(posedge clk); #1;
            rx_dv = 1'b0;
            if (gaps && k < N - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        first_dv_q.push_back(last + bubble_cycles(f) + 1);
        check("busy_after_collect", o_busy, 1);
        if (sort_drop) begin
            rx_dv = 1'b1;
            rx_byte = 8'hAA;
            drop_q.push_back(cyc + 1);
            @(posedge clk); #1;
            rx_dv = 1'b0;
        end
    endtask

    task automatic wait_frame(input bit wait_drop);
        int start = frames_done;
        int budget = 0;
        bit dropped = 1'b0;
        while (frames_done == start && budget < 3000) begin
            if (wait_drop && !dropped && o_Tx_DV) begin
                @(posedge clk); #1;
                rx_dv = 1'b1;
                rx_byte = 8'hAA;
                drop_q.push_back(cyc + 1);
                dropped = 1'b1;
                @(posedge clk); #1;
                rx_dv = 1'b0;
                budget += 2;
            end else begin
                @(posedge clk); #1;
                budget++;
            end
        end
        check("frame_completed", frames_done - start, 1);
    endtask

    // Transmitter model: acknowledge each o_Tx_DV after 1..4 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_Tx_DV) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                end
                if (rst_n) begin
                    tx_done = 1'b1;
                    last_done_cyc = cyc;
                    done_in_frame++;
                    if (expect_final) begin
                        fd_exp_cyc = cyc + 1;
                        expect_final = 1'b0;
                        done_in_frame = 0;
                    end
                    @(posedge clk); #1;
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every DUT output event against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_Tx_DV) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_tx: got byte 0x%0h with nothing expected", o_Tx_Byte);
                    end else begin
                        check("tx_byte", o_Tx_Byte, exp_q.pop_front());
                        check("busy_in_send", o_busy, 1);
                        if (mon_idx == 0) check("first_dv_cycle", cyc, first_dv_q.pop_front());
                        else check("dv_after_done_cycle", cyc, last_done_cyc + 1);
                        mon_idx++;
                        if (mon_idx == N) begin
                            mon_idx = 0;
                            expect_final = 1'b1;
                        end
                    end
                end
                if (fd_exp_cyc == cyc) begin
                    check("frame_done", o_frame_done, 1);
                    if (o_frame_done) frames_done++;
                    fd_exp_cyc = -1;
                end else if (o_frame_done) begin
                    check("frame_done_unexpected", o_frame_done, 0);
                end
                if (o_drop) begin
                    if (drop_q.size() == 0) check("drop_unexpected", o_drop, 0);
                    else check("drop_cycle", cyc, drop_q.pop_front());
                end else if (drop_q.size() > 0 && drop_q[0] <= cyc) begin
                    check("drop_pulse", o_drop, 1);
                    void'(drop_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];
        int budget;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_Tx_DV, o_Tx_Byte, o_busy, o_drop, o_frame_done}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Already sorted
        f.delete();
        for (int k = 0; k < N; k++) f.push_back(8'(k + 1));
        send_frame(f, 1'b0, 1'b0);
        wait_frame(1'b0);

        // Strictly descending
        f.delete();
        for (int k = 0; k < N; k++) f.push_back(8'(N - k));
        send_frame(f, 1'b0, 1'b0);
        wait_frame(1'b0);

        // Extremes and duplicates
        f = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01};
        send_frame(f, 1'b0, 1'b1);
        wait_frame(1'b0);

        // Overrun during SORT and WAIT_TX
        f.delete();
        for (int k = 0; k < N; k++) f.push_back(8'($urandom_range(0, 255)));
        send_frame(f, 1'b1, 1'b0);
        wait_frame(1'b1);

        // Reset after the third acknowledged byte
        f.delete();
        for (int k = 0; k < N; k++) f.push_back(8'($urandom_range(0, 255)));
        send_frame(f, 1'b0, 1'b1);
        budget = 0;
        while (done_in_frame < 3 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("third_done_seen", done_in_frame, 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("outputs_after_async_reset", {o_Tx_DV, o_Tx_Byte, o_busy, o_drop, o_frame_done}, 0);
        exp_q.delete();
        first_dv_q.delete();
        mon_idx = 0;
        expect_final = 1'b0;
        done_in_frame = 0;
        fd_exp_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        f.delete();
        for (int k = 0; k < N; k++) f.push_back(8'(8'h10 + k));
        send_frame(f, 1'b0, 1'b0);
        wait_frame(1'b0);

        // Random frames, back-to-back, some with heavy duplication and overruns
        for (int r = 0; r < 20; r++) begin
            bit dup = ($urandom_range(0, 2) == 0);
            f.delete();
            for (int k = 0; k < N; k++) begin
                f.push_back(dup ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
            end
            send_frame(f, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            wait_frame($urandom_range(0, 3) == 0);
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        check("drops_all_seen", drop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
